// File: rtl/q_mult_pkg.sv
// Shared fixed-point format constants and helpers
// for the multiplier, adder and divider.
package q_mult_pkg;

  localparam int N_DEF = 32;
  localparam int Q_DEF = 19;

  function automatic int sign_idx(input int n);
    return n - 1;
  endfunction

endpackage

// File: rtl/q_mult_if.sv
// Operand/result bundle for the Q-format multiplier.
// master drives operands, slave returns the product.
interface q_mult_if #(
  parameter int N = 32
);

  logic         i_valid;
  logic [N-1:0] i_multiplicand;
  logic [N-1:0] i_multiplier;
  logic [N-1:0] o_result;
  logic         ovr;
  logic         o_valid;

  modport master (
    output i_valid,
    output i_multiplicand,
    output i_multiplier,
    input  o_result,
    input  ovr,
    input  o_valid
  );

  modport slave (
    input  i_valid,
    input  i_multiplicand,
    input  i_multiplier,
    output o_result,
    output ovr,
    output o_valid
  );

endinterface

// File: rtl/q_mult_core.sv
// Combinational signed-magnitude Q-format multiply:
// truncated result window plus overflow flag.
module qmult_core
  import q_mult_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int Q = Q_DEF
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] result,
  output logic         ovr
);

  localparam int S = sign_idx(N);
  localparam int PW = 2 * N - 2;

  logic [PW-1:0] a_mag;
  logic [PW-1:0] b_mag;
  logic [PW-1:0] prod;

  // Zero-extend so the product is full width.
  assign a_mag = {{(N-1){1'b0}}, a[N-2:0]};
  assign b_mag = {{(N-1){1'b0}}, b[N-2:0]};
  assign prod  = a_mag * b_mag;

  assign result[S]     = a[S] ^ b[S];
  assign result[N-2:0] = prod[N-2+Q:Q];
  assign ovr           = |prod[PW-1:N-1+Q];

endmodule

// File: rtl/q_mult.sv
// Q-format multiplier with one registered output
// stage around the combinational core.
module q_mult
  import q_mult_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int Q = Q_DEF
) (
  input logic i_clk,
  input logic i_rst_n,
  q_mult_if.slave bus
);

  logic [N-1:0] core_result;
  logic         core_ovr;

  qmult_core #(
    .N (N),
    .Q (Q)
  ) u_core (
    .a      (bus.i_multiplicand),
    .b      (bus.i_multiplier),
    .result (core_result),
    .ovr    (core_ovr)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      bus.o_result <= '0;
      bus.ovr      <= 1'b0;
      bus.o_valid  <= 1'b0;
    end else begin
      bus.o_valid <= bus.i_valid;
      if (bus.i_valid) begin
        bus.o_result <= core_result;
        bus.ovr      <= core_ovr;
      end
    end
  end

endmodule

// File: tb/tb_q_mult.sv
// Directed vector bench for q_mult at N=32, Q=19.
// Table vectors plus streaming, hold and reset cases.
module tb_q_mult;

  localparam int N = 32;
  localparam int Q = 19;

  logic i_clk;
  logic i_rst_n;

  q_mult_if #(.N(N)) bus ();

  q_mult #(.N(N), .Q(Q)) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .bus     (bus.slave)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    logic        v;
  } vec_t;

  int n_vec;
  int n_bad;

  task automatic chk(
    input string       name,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [32:0] model(
    input logic [31:0] a,
    input logic [31:0] b
  );
    logic [63:0] p;
    logic [31:0] r;
    p = {33'd0, a[30:0]} * {33'd0, b[30:0]};
    r = {a[31] ^ b[31], p[49:19]};
    return {|p[61:50], r};
  endfunction

  task automatic apply(
    input logic [31:0] a,
    input logic [31:0] b
  );
    @(negedge i_clk);
    bus.i_valid        = 1'b1;
    bus.i_multiplicand = a;
    bus.i_multiplier   = b;
    @(posedge i_clk);
    #1;
  endtask

  vec_t        tbl [12];
  logic [31:0] b;
  logic [32:0] g;
  logic [31:0] last_r;
  logic        last_v;

  initial begin
    n_vec = 0;
    n_bad = 0;
    tbl[0]  = '{32'h001921FB, 32'h00080000, 32'h001921FB, 1'b0};
    tbl[1]  = '{32'h001921FB, 32'h00000001, 32'h00000003, 1'b0};
    tbl[2]  = '{32'h001921FB, 32'h00000003, 32'h00000009, 1'b0};
    tbl[3]  = '{32'h001921FB, 32'h80080000, 32'h801921FB, 1'b0};
    tbl[4]  = '{32'h801921FB, 32'h80080000, 32'h001921FB, 1'b0};
    tbl[5]  = '{32'h80000000, 32'h00080000, 32'h80000000, 1'b0};
    tbl[6]  = '{32'h7FFFFFFF, 32'h00100000, 32'h7FFFFFFE, 1'b1};
    tbl[7]  = '{32'h000C0000, 32'h000C0000, 32'h00120000, 1'b0};
    tbl[8]  = '{32'h00100000, 32'h00100000, 32'h00200000, 1'b0};
    tbl[9]  = '{32'h00040000, 32'h80040000, 32'h80020000, 1'b0};
    tbl[10] = '{32'h02000000, 32'h02000000, 32'h00000000, 1'b1};
    tbl[11] = '{32'h02000000, 32'h01F80000, 32'h7E000000, 1'b0};

    bus.i_valid        = 1'b0;
    bus.i_multiplicand = '0;
    bus.i_multiplier   = '0;
    i_rst_n = 1'b1;
    #2 i_rst_n = 1'b0;
    #1;
    chk("rst_result", bus.o_result, 32'h0);
    chk("rst_ovr", {31'd0, bus.ovr}, 32'h0);
    chk("rst_valid", {31'd0, bus.o_valid}, 32'h0);
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    i_rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      apply(tbl[i].a, tbl[i].b);
      chk($sformatf("vec%0d_r", i), bus.o_result, tbl[i].r);
      chk($sformatf("vec%0d_ovr", i),
          {31'd0, bus.ovr}, {31'd0, tbl[i].v});
      chk($sformatf("vec%0d_vld", i),
          {31'd0, bus.o_valid}, 32'h1);
    end

    b = 32'h0;
    for (int i = 0; i < 31; i++) begin
      b[30:0] = {b[29:0], 1'b1};
      g = model(32'h001921FB, b);
      apply(32'h001921FB, b);
      chk($sformatf("stream%0d_r", i), bus.o_result, g[31:0]);
      chk($sformatf("stream%0d_ovr", i),
          {31'd0, bus.ovr}, {31'd0, g[32]});
      chk($sformatf("stream%0d_vld", i),
          {31'd0, bus.o_valid}, 32'h1);
      last_r = g[31:0];
      last_v = g[32];
    end

    for (int i = 0; i < 2; i++) begin
      @(negedge i_clk);
      bus.i_valid        = 1'b0;
      bus.i_multiplicand = 32'h00100000;
      bus.i_multiplier   = 32'h00100000;
      @(posedge i_clk);
      #1;
      chk("hold_r", bus.o_result, last_r);
      chk("hold_ovr", {31'd0, bus.ovr}, {31'd0, last_v});
      chk("hold_vld", {31'd0, bus.o_valid}, 32'h0);
    end

    apply(32'h000C0000, 32'h000C0000);
    chk("pre_rst_r", bus.o_result, 32'h00120000);
    @(negedge i_clk);
    bus.i_valid        = 1'b1;
    bus.i_multiplicand = 32'h7FFFFFFF;
    bus.i_multiplier   = 32'h00100000;
    #2 i_rst_n = 1'b0;
    #1;
    chk("midrst_r", bus.o_result, 32'h0);
    chk("midrst_ovr", {31'd0, bus.ovr}, 32'h0);
    chk("midrst_vld", {31'd0, bus.o_valid}, 32'h0);
    @(posedge i_clk);
    @(negedge i_clk);
    bus.i_valid = 1'b0;
    i_rst_n = 1'b1;
    @(posedge i_clk);
    #1;
    chk("post_rst_vld", {31'd0, bus.o_valid}, 32'h0);
    chk("post_rst_r", bus.o_result, 32'h0);

    apply(32'h001921FB, 32'h00080000);
    chk("first_after_rst_r", bus.o_result, 32'h001921FB);
    chk("first_after_rst_vld",
        {31'd0, bus.o_valid}, 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
